// File: rtl/fxu_pkg.sv
// rtl/fxu_pkg.sv - opcodes, default sizes and entry layout for the FXU reservation station
package fxu_pkg;
  localparam int TAGW  = 4;
  localparam int DEPTH = 4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_MOVL = 4'b0101;
  localparam logic [3:0] OP_MOVH = 4'b0110;

  typedef struct packed {
    logic            busy;
    logic [3:0]      opcode;
    logic [TAGW-1:0] index;
    logic [7:0]      imm;
    logic            ra;
    logic [15:0]     va;
    logic [TAGW-1:0] qa;
    logic            rb;
    logic [15:0]     vb;
    logic [TAGW-1:0] qb;
  } rs_entry_t;
endpackage

// File: rtl/fxu_rs_entry.sv
// rtl/fxu_rs_entry.sv - one reservation-station slot: dispatch write, CDB snoop, ready flag
module fxu_rs_entry
  import fxu_pkg::*;
#(
  parameter int TAGW = fxu_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            wr_en,
  input  logic            clr,
  input  logic [3:0]      wr_opcode,
  input  logic [TAGW-1:0] wr_index,
  input  logic [7:0]      wr_imm,
  input  logic            wr_ra,
  input  logic [15:0]     wr_va,
  input  logic [TAGW-1:0] wr_qa,
  input  logic            wr_rb,
  input  logic [15:0]     wr_vb,
  input  logic [TAGW-1:0] wr_qb,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_index,
  input  logic [15:0]     cdb_value,
  output logic            busy,
  output logic            ready,
  output logic [3:0]      opcode,
  output logic [TAGW-1:0] index,
  output logic [7:0]      imm,
  output logic [15:0]     va,
  output logic [15:0]     vb
);
  logic            ra, rb;
  logic [TAGW-1:0] qa, qb;
  logic            hit_wa, hit_wb, hit_a, hit_b;

  // A result broadcast in the dispatch cycle would otherwise be missed forever
  assign hit_wa = !wr_ra && cdb_valid && (wr_qa == cdb_index);
  assign hit_wb = !wr_rb && cdb_valid && (wr_qb == cdb_index);
  assign hit_a  = busy && !ra && cdb_valid && (qa == cdb_index);
  assign hit_b  = busy && !rb && cdb_valid && (qb == cdb_index);
  assign ready  = busy && ra && rb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      opcode <= '0;
      index  <= '0;
      imm    <= '0;
      ra     <= 1'b0;
      va     <= '0;
      qa     <= '0;
      rb     <= 1'b0;
      vb     <= '0;
      qb     <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (wr_en) begin
      busy   <= 1'b1;
      opcode <= wr_opcode;
      index  <= wr_index;
      imm    <= wr_imm;
      ra     <= wr_ra | hit_wa;
      va     <= hit_wa ? cdb_value : wr_va;
      qa     <= wr_qa;
      rb     <= wr_rb | hit_wb;
      vb     <= hit_wb ? cdb_value : wr_vb;
      qb     <= wr_qb;
    end else begin
      if (clr) busy <= 1'b0;
      if (hit_a) begin
        ra <= 1'b1;
        va <= cdb_value;
      end
      if (hit_b) begin
        rb <= 1'b1;
        vb <= cdb_value;
      end
    end
  end
endmodule

// File: rtl/fxu_rs.sv
// rtl/fxu_rs.sv - FXU reservation station: lowest-free dispatch, lowest-ready issue register
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int DEPTH = fxu_pkg::DEPTH,
  parameter int TAGW  = fxu_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [TAGW-1:0] in_index,
  input  logic [7:0]      in_i,
  input  logic            in_ra,
  input  logic            in_rb,
  input  logic [15:0]     in_va,
  input  logic [15:0]     in_vb,
  input  logic [TAGW-1:0] in_qa,
  input  logic [TAGW-1:0] in_qb,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_index,
  input  logic [15:0]     cdb_value,
  input  logic            flush,
  output logic            out_valid,
  output logic [3:0]      out_opcode,
  output logic [TAGW-1:0] out_index,
  output logic [15:0]     out_va,
  output logic [15:0]     out_vb,
  output logic [7:0]      out_i
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy, ready, wr_en, clr;
  logic [3:0]       e_opcode [DEPTH];
  logic [TAGW-1:0]  e_index  [DEPTH];
  logic [7:0]       e_imm    [DEPTH];
  logic [15:0]      e_va     [DEPTH];
  logic [15:0]      e_vb     [DEPTH];
  logic [IW-1:0]    free_sel, iss_sel;
  logic             any_ready;

  // Both pickers scan downward so the lowest index wins
  always_comb begin
    free_sel  = '0;
    iss_sel   = '0;
    any_ready = |ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i])  free_sel = IW'(i);
      if (ready[i])  iss_sel  = IW'(i);
    end
  end

  assign in_ready = ~&busy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign wr_en[g] = in_valid && in_ready && (free_sel == IW'(g));
    assign clr[g]   = any_ready && (iss_sel == IW'(g));

    fxu_rs_entry #(.TAGW(TAGW)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .wr_en     (wr_en[g]),
      .clr       (clr[g]),
      .wr_opcode (in_opcode),
      .wr_index  (in_index),
      .wr_imm    (in_i),
      .wr_ra     (in_ra),
      .wr_va     (in_va),
      .wr_qa     (in_qa),
      .wr_rb     (in_rb),
      .wr_vb     (in_vb),
      .wr_qb     (in_qb),
      .cdb_valid (cdb_valid),
      .cdb_index (cdb_index),
      .cdb_value (cdb_value),
      .busy      (busy[g]),
      .ready     (ready[g]),
      .opcode    (e_opcode[g]),
      .index     (e_index[g]),
      .imm       (e_imm[g]),
      .va        (e_va[g]),
      .vb        (e_vb[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_index  <= '0;
      out_va     <= '0;
      out_vb     <= '0;
      out_i      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (any_ready) begin
      out_valid  <= 1'b1;
      out_opcode <= e_opcode[iss_sel];
      out_index  <= e_index[iss_sel];
      out_va     <= e_va[iss_sel];
      out_vb     <= e_vb[iss_sel];
      out_i      <= e_imm[iss_sel];
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fxu_rs.sv
// tb/tb_fxu_rs.sv - directed self-checking bench for fxu_rs
module tb_fxu_rs;
  import fxu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_index = '0;
  logic [7:0]  in_i = '0;
  logic        in_ra = 1'b0, in_rb = 1'b0;
  logic [15:0] in_va = '0, in_vb = '0;
  logic [3:0]  in_qa = '0, in_qb = '0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_index = '0;
  logic [15:0] cdb_value = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [3:0]  out_opcode;
  logic [3:0]  out_index;
  logic [15:0] out_va, out_vb;
  logic [7:0]  out_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fxu_rs #(.DEPTH(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_index(in_index), .in_i(in_i),
    .in_ra(in_ra), .in_rb(in_rb), .in_va(in_va), .in_vb(in_vb),
    .in_qa(in_qa), .in_qb(in_qb), .cdb_valid(cdb_valid),
    .cdb_index(cdb_index), .cdb_value(cdb_value), .flush(flush),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_index(out_index),
    .out_va(out_va), .out_vb(out_vb), .out_i(out_i)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [3:0] idx, input logic [7:0] imm,
                          input logic ra, input logic [15:0] va, input logic [3:0] qa,
                          input logic rb, input logic [15:0] vb, input logic [3:0] qb);
    in_valid = 1'b1; in_opcode = op; in_index = idx; in_i = imm;
    in_ra = ra; in_va = va; in_qa = qa;
    in_rb = rb; in_vb = vb; in_qb = qb;
  endtask

  task automatic set_cdb(input logic [3:0] idx, input logic [15:0] v);
    cdb_valid = 1'b1; cdb_index = idx; cdb_value = v;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_flags: got %b expected 01", {out_valid, in_ready});
    end
    checks++;
    if ({out_opcode, out_index, out_va, out_vb, out_i} !== 48'h0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {out_opcode, out_index, out_va, out_vb, out_i});
    end
    tick; rst = 1'b0; tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_add;
    set_disp(OP_ADD, 4'd3, 8'h00, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
    tick; idle;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_early: got %b expected 0", out_valid);
    end
    tick;
    checks++;
    if ({out_valid, out_opcode, out_index, out_va, out_vb} !== {1'b1, OP_ADD, 4'd3, 16'd5, 16'd7}) begin
      errors++; $display("FAIL add_issue: got %h expected %h", {out_valid, out_opcode, out_index, out_va, out_vb},
                         {1'b1, OP_ADD, 4'd3, 16'd5, 16'd7});
    end
    checks++;
    if ((17'(out_va) + 17'(out_vb)) !== 17'd12) begin
      errors++; $display("FAIL add_sum: got %0d expected 12", 17'(out_va) + 17'(out_vb));
    end
    tick;
    checks++;
    if ({out_valid, out_index, out_va, in_ready} !== {1'b0, 4'd3, 16'd5, 1'b1}) begin
      errors++; $display("FAIL add_hold: got %h expected %h", {out_valid, out_index, out_va, in_ready},
                         {1'b0, 4'd3, 16'd5, 1'b1});
    end
  endtask

  task automatic test_wakeup;
    set_disp(OP_SUB, 4'd2, 8'h5A, 1'b0, 16'h0, 4'd1, 1'b1, 16'h0003, 4'd0);
    tick; idle;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL wake_wait%0d: got %b expected 0", k, out_valid);
      end
    end
    set_cdb(4'd1, 16'h0010);
    tick; idle;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL wake_edge: got %b expected 0", out_valid);
    end
    tick;
    checks++;
    if ({out_valid, out_opcode, out_index, out_va, out_vb, out_i} !==
        {1'b1, OP_SUB, 4'd2, 16'h0010, 16'h0003, 8'h5A}) begin
      errors++; $display("FAIL wake_issue: got %h expected %h", {out_valid, out_opcode, out_index, out_va, out_vb, out_i},
                         {1'b1, OP_SUB, 4'd2, 16'h0010, 16'h0003, 8'h5A});
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL wake_once: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_bypass;
    set_disp(OP_MOV, 4'd6, 8'h11, 1'b1, 16'h0001, 4'd0, 1'b0, 16'h0, 4'd5);
    set_cdb(4'd5, 16'hBEEF);
    tick; idle; tick;
    checks++;
    if ({out_valid, out_opcode, out_index, out_va, out_vb} !== {1'b1, OP_MOV, 4'd6, 16'h0001, 16'hBEEF}) begin
      errors++; $display("FAIL bypass_issue: got %h expected %h", {out_valid, out_opcode, out_index, out_va, out_vb},
                         {1'b1, OP_MOV, 4'd6, 16'h0001, 16'hBEEF});
    end
    set_disp(OP_MOVL, 4'd7, 8'h22, 1'b0, 16'h0, 4'd9, 1'b1, 16'h0002, 4'd0);
    set_cdb(4'd8, 16'h1234);
    tick; idle; tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_tag_miss: got %b expected 0", out_valid);
    end
    set_cdb(4'd9, 16'h4321);
    tick; idle; tick;
    checks++;
    if ({out_valid, out_index, out_va, out_vb} !== {1'b1, 4'd7, 16'h4321, 16'h0002}) begin
      errors++; $display("FAIL bypass_late_wake: got %h expected %h", {out_valid, out_index, out_va, out_vb},
                         {1'b1, 4'd7, 16'h4321, 16'h0002});
    end
  endtask

  task automatic test_full;
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL full_ready%0d: got %b expected 1", k, in_ready);
      end
      set_disp(OP_ADD, 4'(8 + k), 8'h00, 1'b0, 16'h0, 4'(1 + k), 1'b1, 16'(16'h0100 + k), 4'd0);
      tick; idle;
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_not_ready: got %b expected 0", in_ready);
    end
    set_disp(OP_ADD, 4'd12, 8'h00, 1'b1, 16'hAAAA, 4'd0, 1'b1, 16'hBBBB, 4'd0);
    tick; idle; tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_drop: got %b expected 0", out_valid);
    end
    set_cdb(4'd3, 16'h0033);
    tick; idle;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL full_select_cycle: got %b expected 00", {in_ready, out_valid});
    end
    tick;
    checks++;
    if ({out_valid, out_index, out_va, out_vb} !== {1'b1, 4'd10, 16'h0033, 16'h0102}) begin
      errors++; $display("FAIL full_issue: got %h expected %h", {out_valid, out_index, out_va, out_vb},
                         {1'b1, 4'd10, 16'h0033, 16'h0102});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_back: got %b expected 1", in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_no_ghost: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_same_cdb;
    flush = 1'b1; tick; idle;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL order_flush: got %b expected 10", {in_ready, out_valid});
    end
    set_disp(OP_ADD, 4'd1, 8'h00, 1'b0, 16'h0, 4'd7, 1'b1, 16'h0001, 4'd0);  tick;
    set_disp(OP_ADD, 4'd2, 8'h00, 1'b0, 16'h0, 4'd9, 1'b1, 16'h0002, 4'd0);  tick;
    set_disp(OP_ADD, 4'd3, 8'h00, 1'b0, 16'h0, 4'd10, 1'b1, 16'h0003, 4'd0); tick;
    set_disp(OP_ADD, 4'd4, 8'h00, 1'b0, 16'h0, 4'd7, 1'b1, 16'h0004, 4'd0);  tick;
    idle;
    set_cdb(4'd7, 16'h0777);
    tick; idle; tick;
    checks++;
    if ({out_valid, out_index, out_va, out_vb} !== {1'b1, 4'd1, 16'h0777, 16'h0001}) begin
      errors++; $display("FAIL order_first: got %h expected %h", {out_valid, out_index, out_va, out_vb},
                         {1'b1, 4'd1, 16'h0777, 16'h0001});
    end
    tick;
    checks++;
    if ({out_valid, out_index, out_va, out_vb} !== {1'b1, 4'd4, 16'h0777, 16'h0004}) begin
      errors++; $display("FAIL order_second: got %h expected %h", {out_valid, out_index, out_va, out_vb},
                         {1'b1, 4'd4, 16'h0777, 16'h0004});
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL order_done: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush;
    flush = 1'b1; tick; idle;
    set_disp(OP_SUB, 4'd5, 8'h00, 1'b0, 16'h0, 4'd12, 1'b1, 16'h0005, 4'd0); tick;
    set_disp(OP_ADD, 4'd6, 8'h00, 1'b1, 16'h0006, 4'd0, 1'b1, 16'h0006, 4'd0); tick;
    idle;
    flush = 1'b1;
    set_cdb(4'd12, 16'h00CC);
    set_disp(OP_ADD, 4'd13, 8'h00, 1'b1, 16'h000D, 4'd0, 1'b1, 16'h000D, 4'd0);
    tick; idle;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_clear: got %b expected 01", {out_valid, in_ready});
    end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_quiet%0d: got %b expected 0", k, out_valid);
      end
    end
    set_cdb(4'd12, 16'h00CC);
    tick; idle; tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_wake: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_rst_mid;
    set_disp(OP_SUB, 4'd8, 8'h00, 1'b0, 16'h0, 4'd13, 1'b1, 16'h0008, 4'd0); tick;
    set_disp(OP_ADD, 4'd9, 8'h99, 1'b1, 16'h0009, 4'd0, 1'b1, 16'h0009, 4'd0); tick;
    set_disp(OP_MOVH, 4'd10, 8'h00, 1'b1, 16'h000A, 4'd0, 1'b1, 16'h000A, 4'd0); tick;
    idle;
    checks++;
    if ({out_valid, out_index} !== {1'b1, 4'd9}) begin
      errors++; $display("FAIL rst_pre_issue: got %h expected %h", {out_valid, out_index}, {1'b1, 4'd9});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_async: got %b expected 01", {out_valid, in_ready});
    end
    checks++;
    if ({out_opcode, out_index, out_va, out_vb, out_i} !== 48'h0) begin
      errors++; $display("FAIL rst_fields: got %h expected 0", {out_opcode, out_index, out_va, out_vb, out_i});
    end
    tick; rst = 1'b0;
    set_cdb(4'd13, 16'h00DD);
    tick; idle;
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_dropped%0d: got %b expected 0", k, out_valid);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_wakeup;
    test_bypass;
    test_full;
    test_same_cdb;
    test_flush;
    test_rst_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fxu_rs.md
FXU_RS -- requirements
Module: fxu_rs

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries.
REQ-002 Parameter TAGW, default 4, ROB index width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  dispatch request.
REQ-006 in_ready  output  1  free entry exists; a dispatch is accepted only when in_valid && in_ready.
REQ-007 in_opcode, in_index, in_i  input  4/TAGW/8  opcode, destination ROB index, 8-bit immediate.
REQ-008 in_ra, in_rb  input  1 each  operand A/B value present at dispatch.
REQ-009 in_va, in_vb  input  16 each  operand value, meaningful when the matching in_r* is high.
REQ-010 in_qa, in_qb  input  TAGW each  producing ROB tag, meaningful when the matching in_r* is low.
REQ-011 cdb_valid, cdb_index, cdb_value  input  1/TAGW/16  result broadcast (FXU out_valid/out_rob_index/out_return_value).
REQ-012 flush  input  1  discard all held and issuing ops.
REQ-013 out_valid, out_opcode, out_index  output  1/4/TAGW  issue to FXU in_valid/in_opcode/in_index.
REQ-014 out_va, out_vb, out_i  output  16/16/8  issue operands to FXU.

Function
REQ-015 Each entry SHALL hold: busy, opcode, index, imm, ra, va, qa, rb, vb, qb.
REQ-016 in_ready SHALL be high iff at least one entry is not busy in registered state; freeing by same-cycle issue SHALL NOT raise in_ready that cycle.
REQ-017 An accepted dispatch SHALL write the lowest-numbered non-busy entry and set busy.
REQ-018 Wake-up: on cdb_valid, every busy entry with ra==0 and qa==cdb_index SHALL set ra=1, va=cdb_value; same for B.
REQ-019 Dispatch bypass: if in_ra==0, cdb_valid and in_qa==cdb_index in the dispatch cycle, the entry SHALL be written with ra=1, va=cdb_value; same for B.
REQ-020 An entry is ready when busy && ra && rb in registered state.
REQ-021 Each cycle the lowest-numbered ready entry SHALL be selected; on the next edge out_* SHALL load its fields, out_valid=1, and the entry's busy SHALL clear.
REQ-022 No ready entry: out_valid SHALL be 0 after the edge; out_va/out_vb/out_i/out_opcode/out_index hold previous values.
REQ-023 At most one issue per cycle; the FXU always accepts, no issue backpressure.
REQ-024 Latency: dispatch with both operands ready at edge k -> out_valid high in the cycle after edge k+1; CDB wake-up at edge k -> earliest issue at edge k+1.
REQ-025 Dispatch and issue in the same cycle SHALL both complete; a dispatch never targets the entry being issued.
REQ-026 flush high at an edge SHALL clear every busy, clear out_valid, and ignore in_valid and cdb_valid for that edge.
REQ-027 Full (all busy): in_ready=0, in_valid ignored, wake-up and issue continue.
REQ-028 Operand values are 16-bit, stored without modification; immediate stays 8-bit.

Reset
REQ-029 rst high SHALL asynchronously clear all busy bits and out_valid; in_ready SHALL read 1.
REQ-030 After rst, out_opcode, out_index, out_va, out_vb, out_i SHALL be 0.
REQ-031 rst mid-operation SHALL drop all held ops without issuing them.

Structure
REQ-032 Package fxu_pkg SHALL hold the opcode constants (ADD 0000, SUB 0001, MOV 0100, MOVL 0101, MOVH 0110), TAGW, DEPTH default, and the entry struct typedef.
REQ-033 One sub-module fxu_rs_entry SHALL implement a single entry (write, CDB snoop, ready flag), instantiated DEPTH times; selection and issue register stay in fxu_rs.

Verification
REQ-034 Reset, then dispatch ADD idx 3, va=5, vb=7, both ready -> out_valid two edges later with out_index=3, out_va=5, out_vb=7; FXU returns 12.
REQ-035 Dispatch SUB idx 2 with qa=1 unready; three idle cycles; cdb idx 1 value 0x0010 -> issue one edge after wake-up with out_va=0x0010.
REQ-036 Dispatch with in_qb=5 in the same cycle as cdb idx 5 value 0xBEEF -> entry issues with out_vb=0xBEEF, no hang.
REQ-037 Four unready dispatches -> in_ready=0, fifth in_valid ignored; wake entry 2 -> issues, in_ready returns 1 the cycle after.
REQ-038 Entries 0 and 3 woken by the same CDB -> entry 0 issues first, entry 3 next cycle.
REQ-039 Fill two entries, assert flush -> out_valid=0 next cycle, in_ready=1, no later issue; same with rst asserted mid-cycle.
